alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end that serializes ALU operations through IDLE, LOAD, EXEC and RESP phases.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin contention; by default requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_func,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_func,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             alu_wren_a,
  output logic             alu_wren_b,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] op_a_r, op_b_r, rsp_data_r;
  logic [3:0]       func_r;
  logic             id_r, rsp_id_r;
  logic             grant_id_s, accept_s;

  assign accept_s = (state_r == IDLE) && (req_valid != 2'b00);

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic last_grant_r;

  // Contention goes to the requester that was not granted last time.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_id_s = ~last_grant_r;
    end else begin
      grant_id_s = ~req_valid[0];
    end
  end

  // Pointer moves only when a request is actually accepted; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= grant_id_s;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    grant_id_s = ~req_valid[0];
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: next_state_s = EXEC;
      EXEC: next_state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Latch the winning request on acceptance and capture the ALU result in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      func_r     <= 4'd0;
      id_r       <= 1'b0;
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_id_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        op_a_r <= grant_id_s ? req1_a : req0_a;
        op_b_r <= grant_id_s ? req1_b : req0_b;
        func_r <= grant_id_s ? req1_func : req0_func;
        id_r   <= grant_id_s;
      end
      if (state_r == EXEC) begin
        rsp_data_r <= alu_result;
        rsp_id_r   <= id_r;
      end
    end
  end

  // Output decode from the registered state and captured data.
  always_comb begin
    req_ready  = 2'b00;
    rsp_valid  = 1'b0;
    alu_wren_a = 1'b0;
    alu_wren_b = 1'b0;
    alu_in_a   = {WIDTH{1'b0}};
    alu_in_b   = {WIDTH{1'b0}};
    alu_func   = 4'd0;
    busy       = (state_r != IDLE);
    rsp_id     = rsp_id_r;
    rsp_data   = rsp_data_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          req_ready = grant_id_s ? 2'b10 : 2'b01;
        end else begin
          req_ready = 2'b00;
        end
      end
      LOAD: begin
        alu_wren_a = 1'b1;
        alu_wren_b = 1'b1;
        alu_in_a   = op_a_r;
        alu_in_b   = op_b_r;
        alu_func   = func_r;
      end
      EXEC: alu_func = func_r;
      RESP: rsp_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
